// File: rtl/decode_ctrl.sv
// Decode-stage control for the 5-stage RV32I pipeline: control decode, load-use stall and ID/EX register.
// Optional macro DECODE_CTRL_ILLEGAL_EN: flag unlisted opcodes as illegal and turn them into bubbles.
module decode_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush_e,
    output logic [2:0]  immsrc_d,
    output logic        illegal_d,
    output logic        stall_f,
    output logic        stall_d,
    output logic        valid_e,
    output logic        regwrite_e,
    output logic [1:0]  resultsrc_e,
    output logic        memwrite_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        alusrc_e,
    output logic [1:0]  aluop_e,
    output logic [2:0]  funct3_e,
    output logic        funct7b5_e,
    output logic [4:0]  rd_e
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_CMP  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       funct7b5;

    logic       dec_regwrite;
    logic [1:0] dec_resultsrc;
    logic       dec_memwrite;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_alusrc;
    logic [1:0] dec_aluop;
    logic [2:0] dec_immsrc;

    logic       uses_rs1;
    logic       uses_rs2;
    logic       rs1_match;
    logic       rs2_match;
    logic       load_in_e;
    logic       hazard;
    logic       bubble;
    logic       unused_bits;

    assign opcode   = instr_d[6:0];
    assign rd       = instr_d[11:7];
    assign funct3   = instr_d[14:12];
    assign rs1      = instr_d[19:15];
    assign rs2      = instr_d[24:20];
    assign funct7b5 = instr_d[30];

    // Upper funct7 bits other than bit 30 carry no control meaning in RV32I base decode.
    assign unused_bits = &{1'b0, instr_d[31], instr_d[29:25]};

    always_comb begin
        dec_regwrite  = 1'b0;
        dec_resultsrc = RES_ALU;
        dec_memwrite  = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_alusrc    = 1'b0;
        dec_aluop     = ALU_ADD;
        dec_immsrc    = IMM_I;
        case (opcode)
            OP_LW: begin
                dec_regwrite  = 1'b1;
                dec_alusrc    = 1'b1;
                dec_resultsrc = RES_MEM;
            end
            OP_SW: begin
                dec_immsrc    = IMM_S;
                dec_memwrite  = 1'b1;
                dec_alusrc    = 1'b1;
            end
            OP_R: begin
                dec_regwrite  = 1'b1;
                dec_aluop     = ALU_FUNC;
            end
            OP_IALU: begin
                dec_regwrite  = 1'b1;
                dec_alusrc    = 1'b1;
                dec_aluop     = ALU_FUNC;
            end
            OP_BR: begin
                dec_immsrc    = IMM_B;
                dec_branch    = 1'b1;
                dec_aluop     = ALU_CMP;
            end
            OP_JAL: begin
                dec_immsrc    = IMM_J;
                dec_jump      = 1'b1;
                dec_regwrite  = 1'b1;
                dec_resultsrc = RES_PC4;
            end
            OP_JALR: begin
                dec_jump      = 1'b1;
                dec_regwrite  = 1'b1;
                dec_alusrc    = 1'b1;
                dec_resultsrc = RES_PC4;
            end
            OP_LUI: begin
                dec_immsrc    = IMM_U;
                dec_regwrite  = 1'b1;
                dec_alusrc    = 1'b1;
                dec_resultsrc = RES_IMM;
            end
            default: begin
                dec_immsrc    = IMM_I;
            end
        endcase
    end

    assign immsrc_d = dec_immsrc;

`ifdef DECODE_CTRL_ILLEGAL_EN
    logic listed;
    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_R, OP_IALU, OP_BR, OP_JAL, OP_JALR, OP_LUI: listed = 1'b1;
            default:                                                   listed = 1'b0;
        endcase
    end
    assign illegal_d = valid_d & ~listed;
`else
    assign illegal_d = 1'b0;
`endif

    // jal and lui are the only formats whose rs1 field is really immediate bits.
    assign uses_rs1 = (opcode != OP_JAL) && (opcode != OP_LUI);
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BR);

    assign rs1_match = uses_rs1 && (rs1 == rd_e);
    assign rs2_match = uses_rs2 && (rs2 == rd_e);
    assign load_in_e = valid_e && (resultsrc_e == RES_MEM) && (rd_e != 5'd0);
    assign hazard    = valid_d && load_in_e && (rs1_match || rs2_match);

    assign stall_f = hazard;
    assign stall_d = hazard;

    assign bubble = flush_e || hazard || !valid_d || illegal_d;

    // ID/EX boundary: every field is cleared on a bubble so downstream sees no stale control.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_e     <= 1'b0;
            regwrite_e  <= 1'b0;
            resultsrc_e <= 2'b00;
            memwrite_e  <= 1'b0;
            branch_e    <= 1'b0;
            jump_e      <= 1'b0;
            alusrc_e    <= 1'b0;
            aluop_e     <= 2'b00;
            funct3_e    <= 3'b000;
            funct7b5_e  <= 1'b0;
            rd_e        <= 5'd0;
        end else begin
            valid_e     <= 1'b1;
            regwrite_e  <= dec_regwrite;
            resultsrc_e <= dec_resultsrc;
            memwrite_e  <= dec_memwrite;
            branch_e    <= dec_branch;
            jump_e      <= dec_jump;
            alusrc_e    <= dec_alusrc;
            aluop_e     <= dec_aluop;
            funct3_e    <= funct3;
            funct7b5_e  <= funct7b5;
            rd_e        <= rd;
        end
    end

endmodule
